// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - credit-based instruction prefetch queue with redirect flush
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, inflight_q, discard_q;
    logic [CW-1:0] inflight_d, live;
    logic [CW:0]   demand;
    logic [31:0]   fetch_pc_q, rsp_pc_q, redirect_aligned;
    logic          req_fire, rsp_take, push, pop;

    // Slots already promised to outstanding (non-discarded) responses count as occupied.
    assign live             = inflight_q - discard_q;
    assign demand           = {1'b0, count_q} + {1'b0, live};
    assign imem_req_valid   = rst_n && !redirect_valid && (demand < DEPTH_L);
    assign imem_req_addr    = fetch_pc_q;
    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    assign req_fire = imem_req_valid && imem_req_ready;
    // Responses with nothing outstanding belong to requests abandoned by reset.
    assign rsp_take = imem_rsp_valid && (inflight_q != '0);
    assign push     = rsp_take && (discard_q == '0) && !redirect_valid;

    assign out_valid = (count_q != '0) && !redirect_valid;
    assign out_instr = instr_q[head_q];
    assign out_pc    = pc_q[head_q];
    assign pop       = out_valid && out_ready;

    assign inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_take);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            inflight_q <= inflight_d;
            if (redirect_valid) begin
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
                fetch_pc_q <= redirect_aligned;
                rsp_pc_q   <= redirect_aligned;
                discard_q  <= inflight_d;
            end else begin
                if (req_fire)
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                if (rsp_take && (discard_q != '0))
                    discard_q <= discard_q - CW'(1);
                if (push) begin
                    instr_q[tail_q] <= imem_rsp_data;
                    pc_q[tail_q]    <= rsp_pc_q;
                    tail_q          <= tail_q + AW'(1);
                    rsp_pc_q        <= rsp_pc_q + 32'd4;
                end
                if (pop)
                    head_q <= head_q + AW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && ({1'b0, count_q} == DEPTH_L)));
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - randomized bench against a queue-level fetch model
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int rdy; bit stale; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

    pend_t       pend[$];
    ent_t        mq[$];
    logic [31:0] m_fetch_pc;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (pend[i]) if (!pend[i].stale) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock: drive at negedge, check outputs, advance model, take the edge.
    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy, input bit ordy,
                         input int rsp_pct, input int lat_lo, input int lat_hi);
        bit          exp_rv, exp_ov, fire, popd, rsp;
        logic [31:0] ra;
        pend_t       e;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        out_ready      = ordy;
        rsp = (pend.size() > 0) && (pend[0].rdy <= cyc) && (int'($urandom_range(99)) < rsp_pct);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? img(pend[0].addr) : $urandom;
        #1;
        exp_rv = !redir && ((mq.size() + live_cnt()) < DEPTH);
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", imem_req_addr, m_fetch_pc);
        exp_ov = (mq.size() != 0) && !redir;
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check("out_pc", out_pc, mq[0].pc);
            check("out_instr", out_instr, mq[0].ins);
        end
        fire = imem_req_valid && imem_req_ready;
        popd = out_valid && out_ready;
        if (popd && mq.size() > 0) void'(mq.pop_front());
        if (rsp) begin
            e = pend.pop_front();
            if (!e.stale && !redir) mq.push_back('{pc: e.addr, ins: img(e.addr)});
        end
        if (redir) begin
            mq.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            ra = rpc;
            m_fetch_pc = {ra[31:2], 2'b00};
        end
        if (fire) begin
            pend.push_back('{addr: m_fetch_pc, rdy: cyc + int'($urandom_range(lat_hi, lat_lo)), stale: 1'b0});
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_instr"}, out_instr, 32'd0);
        check({tag, "_out_pc"}, out_pc, 32'd0);
    endtask

    initial begin
        logic [31:0] pcs [4];
        logic [31:0] rp;
        pcs[0] = 32'h0000_0040; pcs[1] = 32'h0000_0043;
        pcs[2] = 32'hFFFF_FFF8; pcs[3] = 32'h0000_0100;
        rst_n = 1'b0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        m_fetch_pc = 32'h0;
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("post_rst_req_addr", imem_req_addr, 32'h0);

        repeat (30) cycle(0, 0, 1, 1, 100, 1, 1);
        repeat (20) cycle(0, 0, 1, 0, 100, 1, 1);
        repeat (20) cycle(0, 0, 1, 1, 100, 1, 1);

        for (int k = 0; k < 4; k++) begin
            repeat (6) cycle(0, 0, 1, 1, 100, 2, 3);
            cycle(1, pcs[k], 1, 1, 100, 2, 3);
            repeat (10) cycle(0, 0, 1, 1, 100, 1, 2);
        end
        repeat (4) cycle(0, 0, 1, 1, 100, 3, 3);
        cycle(1, 32'h0000_0200, 1, 1, 100, 1, 3);
        cycle(1, 32'hFFFF_FFFA, 1, 1, 100, 1, 3);
        repeat (12) cycle(0, 0, 1, 1, 100, 1, 3);

        for (int n = 0; n < 3000; n++) begin
            rp = ($urandom_range(1) == 0) ? pcs[$urandom_range(3)] : $urandom;
            cycle($urandom_range(99) < 3, rp, $urandom_range(99) < 70,
                  $urandom_range(99) < 60, 70, 1, 4);
        end

        repeat (8) cycle(0, 0, 1, 0, 100, 3, 3);
        rst_n = 1'b0;
        imem_rsp_valid = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("midrst_hold");
        foreach (pend[i]) pend[i].stale = 1'b1;
        mq.delete();
        m_fetch_pc = 32'h0;
        rst_n = 1'b1;
        for (int g = 0; g < 12 && pend.size() > 0; g++) cycle(0, 0, 0, 1, 100, 1, 1);
        check("late_rsp_drained", 32'(pend.size()), 32'd0);
        pend.delete();
        repeat (30) cycle(0, 0, 1, 1, 100, 1, 1);
        for (int n = 0; n < 500; n++)
            cycle($urandom_range(99) < 4, $urandom, $urandom_range(99) < 80,
                  $urandom_range(99) < 70, 80, 1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 Port: imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 Port: imem_req_addr  output  32  byte address of requested word.
REQ-007 Port: imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 Port: imem_rsp_valid  input  1  instruction word returned this cycle.
REQ-009 Port: imem_rsp_data  input  32  returned instruction word.
REQ-010 Port: redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-011 Port: redirect_pc  input  32  new fetch address.
REQ-012 Port: out_valid  output  1  head entry available to decode/control.
REQ-013 Port: out_instr  output  32  head instruction word.
REQ-014 Port: out_pc  output  32  address of head instruction.
REQ-015 Port: out_ready  input  1  downstream consumes head this cycle.

Function
REQ-016 Request accepted when imem_req_valid && imem_req_ready; on accept, fetch_pc SHALL increment by 4 (mod 2^32, wrap silently).
REQ-017 imem_req_addr SHALL equal fetch_pc; low two bits always 00 (redirect_pc[1:0] ignored, forced 0).
REQ-018 imem_req_valid SHALL be 1 iff !redirect_valid && (count + live) < DEPTH, where count = queue occupancy, live = inflight - discard.
REQ-019 Memory responses return in request order, at least 1 cycle after acceptance; inflight SHALL increment per accepted request and decrement per response, both in the same cycle netting to no change.
REQ-020 Response SHALL be dropped if discard > 0 (discard decrements) or redirect_valid is 1 that cycle; otherwise pushed at tail with pc = rsp_pc, and rsp_pc increments by 4.
REQ-021 Credit rule of REQ-018 guarantees a kept response never meets a full queue; push into full queue SHALL not occur and is an assertion error.
REQ-022 out_valid SHALL be (count != 0) && !redirect_valid; out_instr/out_pc SHALL show head entry combinationally from storage.
REQ-023 Pop when out_valid && out_ready; push and pop in the same cycle SHALL leave count unchanged, including at count = DEPTH-1 and count = 1.
REQ-024 Minimum latency: response in cycle N visible on out_valid in cycle N+1 (registered push, no bypass).
REQ-025 On redirect_valid (edge-sampled): queue emptied (count 0, pointers reset), fetch_pc and rsp_pc <= {redirect_pc[31:2],2'b00}, discard <= inflight_after_this_cycle, no request issued, no pop performed.
REQ-026 Back-to-back redirects SHALL each take effect; last one wins; discard accumulates correctly across them.
REQ-027 After redirect, first request at new address SHALL issue in next cycle if credit allows (live = 0 then).
REQ-028 Pointers SHALL wrap modulo DEPTH; count width log2(DEPTH)+1; inflight/discard width log2(DEPTH)+1, never exceeding DEPTH.

Reset
REQ-029 While rst_n = 0: fetch_pc = rsp_pc = RESET_PC, count = inflight = discard = 0, imem_req_valid = 0, out_valid = 0, out_instr = 0, out_pc = 0.
REQ-030 Reset asserted mid-operation SHALL abandon outstanding requests; responses arriving after deassertion with inflight = 0 SHALL be ignored.
REQ-031 First cycle after rst_n rises: imem_req_valid = 1, imem_req_addr = RESET_PC.

Verification
REQ-032 Streaming: memory 1-cycle latency, ready always 1, out_ready 1 -> out_pc 0,4,8,12... one per cycle, instr matches memory image.
REQ-033 Backpressure: out_ready 0 -> exactly DEPTH (4) requests issued, then imem_req_valid 0; release -> 4 entries drained in order, fetching resumes at 0x10.
REQ-034 Redirect with 2 in flight: redirect_pc 0x40 while responses for 0x8,0xC pending -> both dropped, next out_pc 0x40, no stale instruction ever visible.
REQ-035 Redirect with unaligned redirect_pc 0x43 -> next imem_req_addr 0x40, out_pc 0x40.
REQ-036 Wrap: redirect_pc 0xFFFF_FFF8 -> out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-037 Reset mid-stream with 3 in flight -> all outputs 0 during reset; first post-reset request at RESET_PC, late responses discarded.
